// File: rtl/zet_bus_arb_pkg.sv
// rtl/zet_bus_arb_pkg.sv - shared state encodings and byte-lane constants for the bus arbiter
package zet_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS1 = 2'd1,
    ST_BUS2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

endpackage

// File: rtl/zet_bus_align.sv
// rtl/zet_bus_align.sv - byte-lane steering for writes and read-data assembly
// Steering side sets up the next bus cycle; merge side decodes the cycle being acknowledged.
module zet_bus_align
  import zet_bus_arb_pkg::*;
(
  input  logic        s_adr0,
  input  logic        s_byte,
  input  logic        s_phase2,
  input  logic [15:0] s_wdat,
  output logic [1:0]  s_sel,
  output logic [15:0] s_dat,
  input  logic        m_adr0,
  input  logic        m_byte,
  input  logic        m_phase2,
  input  logic [15:0] m_dat_i,
  input  logic [7:0]  m_lo,
  output logic [15:0] m_rdat
);

  always_comb begin
    s_sel = SEL_WORD;
    s_dat = s_wdat;
    if (s_byte) begin
      s_sel = s_adr0 ? SEL_HI : SEL_LO;
      s_dat = {s_wdat[7:0], s_wdat[7:0]};
    end else if (s_adr0) begin
      // Odd word: low byte goes out on the high lane first, high byte on the low lane next.
      if (!s_phase2) begin
        s_sel = SEL_HI;
        s_dat = {s_wdat[7:0], 8'h00};
      end else begin
        s_sel = SEL_LO;
        s_dat = {8'h00, s_wdat[15:8]};
      end
    end
  end

  always_comb begin
    m_rdat = m_dat_i;
    if (m_byte) begin
      m_rdat = {8'h00, (m_adr0 ? m_dat_i[15:8] : m_dat_i[7:0])};
    end else if (m_adr0) begin
      m_rdat = m_phase2 ? {m_dat_i[7:0], m_lo} : {8'h00, m_dat_i[15:8]};
    end
  end

endmodule

// File: rtl/zet_bus_arb.sv
// rtl/zet_bus_arb.sv - fetch/exec arbiter onto a 16-bit Wishbone master port
// Exec wins ties, a starved fetch goes next, and LOCK keeps the bus (and wb_cyc_o) with exec.
module zet_bus_arb
  import zet_bus_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [19:0] f_adr,
  input  logic        f_byte,
  output logic [15:0] f_dat,
  output logic        f_ack,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [19:0] x_adr,
  input  logic        x_byte,
  input  logic [15:0] x_wdat,
  input  logic        x_lock,
  output logic [15:0] x_rdat,
  output logic        x_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [18:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, wbwe_q, wbwe_d;
  logic [18:0] wbadr_q, wbadr_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [15:0] wbdat_q, wbdat_d;
  logic        f_ack_q, f_ack_d, x_ack_q, x_ack_d;
  logic [15:0] f_dat_q, f_dat_d, x_rdat_q, x_rdat_d;
  logic        fpend_q, fpend_d, own_x_q, own_x_d;
  logic [19:0] adr_q, adr_d;
  logic        byte_q, byte_d, we_q, we_d;
  logic [15:0] wdat_q, wdat_d;
  logic [7:0]  lo_q, lo_d;

  logic        grant_f, grant_x, odd_w, fin;
  logic [19:0] win_adr;
  logic        win_byte;
  logic [15:0] win_wdat;
  logic        s_adr0, s_byte, s_phase2;
  logic [15:0] s_wdat, s_dat, m_rdat;
  logic [1:0]  s_sel;

  always_comb begin
    grant_f  = f_req && !x_lock && (fpend_q || !x_req);
    grant_x  = x_req && !grant_f;
    win_adr  = grant_x ? x_adr : f_adr;
    win_byte = grant_x ? x_byte : f_byte;
    win_wdat = grant_x ? x_wdat : 16'h0000;
    odd_w    = !byte_q && adr_q[0];
    fin      = wb_ack_i && (((state_q == ST_BUS1) && !odd_w) ||
                            ((state_q == ST_BUS2) && stb_q));
    if (state_q == ST_IDLE) begin
      s_adr0   = win_adr[0];
      s_byte   = win_byte;
      s_wdat   = win_wdat;
      s_phase2 = 1'b0;
    end else begin
      s_adr0   = adr_q[0];
      s_byte   = byte_q;
      s_wdat   = wdat_q;
      s_phase2 = 1'b1;
    end
  end

  zet_bus_align u_align (
    .s_adr0   (s_adr0),
    .s_byte   (s_byte),
    .s_phase2 (s_phase2),
    .s_wdat   (s_wdat),
    .s_sel    (s_sel),
    .s_dat    (s_dat),
    .m_adr0   (adr_q[0]),
    .m_byte   (byte_q),
    .m_phase2 (state_q == ST_BUS2),
    .m_dat_i  (wb_dat_i),
    .m_lo     (lo_q),
    .m_rdat   (m_rdat)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    wbwe_d   = wbwe_q;
    wbadr_d  = wbadr_q;
    wbsel_d  = wbsel_q;
    wbdat_d  = wbdat_q;
    f_ack_d  = 1'b0;
    x_ack_d  = 1'b0;
    f_dat_d  = f_dat_q;
    x_rdat_d = x_rdat_q;
    fpend_d  = fpend_q;
    own_x_d  = own_x_q;
    adr_d    = adr_q;
    byte_d   = byte_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_f || grant_x) begin
          own_x_d = grant_x;
          fpend_d = grant_x && f_req;
          adr_d   = win_adr;
          byte_d  = win_byte;
          we_d    = grant_x && x_we;
          wdat_d  = win_wdat;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          wbwe_d  = grant_x && x_we;
          wbadr_d = win_adr[19:1];
          wbsel_d = s_sel;
          wbdat_d = s_dat;
          state_d = ST_BUS1;
        end else begin
          cyc_d = cyc_q && x_lock;
        end
      end
      ST_BUS1: begin
        if (wb_ack_i) begin
          stb_d = 1'b0;
          if (odd_w) begin
            // Address is odd, so +1 always carries into bit 1; 19-bit add wraps 0xFFFFF to 0.
            lo_d    = m_rdat[7:0];
            wbadr_d = adr_q[19:1] + 19'd1;
            wbsel_d = s_sel;
            wbdat_d = s_dat;
            state_d = ST_BUS2;
          end
        end
      end
      ST_BUS2: begin
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wb_ack_i) begin
          stb_d = 1'b0;
        end
      end
      ST_DONE: begin
        cyc_d   = own_x_q && x_lock;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d = ST_DONE;
      cyc_d   = own_x_q && x_lock;
      wbwe_d  = 1'b0;
      if (own_x_q) begin
        x_ack_d = 1'b1;
        if (!we_q) x_rdat_d = m_rdat;
      end else begin
        f_ack_d = 1'b1;
        if (!we_q) f_dat_d = m_rdat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbadr_q  <= '0;
      wbsel_q  <= '0;
      wbdat_q  <= '0;
      f_ack_q  <= 1'b0;
      x_ack_q  <= 1'b0;
      f_dat_q  <= '0;
      x_rdat_q <= '0;
      fpend_q  <= 1'b0;
      own_x_q  <= 1'b0;
      adr_q    <= '0;
      byte_q   <= 1'b0;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      wbwe_q   <= wbwe_d;
      wbadr_q  <= wbadr_d;
      wbsel_q  <= wbsel_d;
      wbdat_q  <= wbdat_d;
      f_ack_q  <= f_ack_d;
      x_ack_q  <= x_ack_d;
      f_dat_q  <= f_dat_d;
      x_rdat_q <= x_rdat_d;
      fpend_q  <= fpend_d;
      own_x_q  <= own_x_d;
      adr_q    <= adr_d;
      byte_q   <= byte_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      lo_q     <= lo_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = wbwe_q;
  assign wb_adr_o = wbadr_q;
  assign wb_sel_o = wbsel_q;
  assign wb_dat_o = wbdat_q;
  assign f_ack    = f_ack_q;
  assign x_ack    = x_ack_q;
  assign f_dat    = f_dat_q;
  assign x_rdat   = x_rdat_q;

endmodule

// File: tb/tb_zet_bus_arb.sv
// tb/tb_zet_bus_arb.sv - directed self-checking bench for zet_bus_arb
module tb_zet_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        f_req = 1'b0;
  logic [19:0] f_adr = '0;
  logic        f_byte = 1'b0;
  logic [15:0] f_dat;
  logic        f_ack;
  logic        x_req = 1'b0;
  logic        x_we = 1'b0;
  logic [19:0] x_adr = '0;
  logic        x_byte = 1'b0;
  logic [15:0] x_wdat = '0;
  logic        x_lock = 1'b0;
  logic [15:0] x_rdat;
  logic        x_ack;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [18:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  ws_cfg = 4'd0;
  logic [3:0]  ws_cnt = 4'd0;
  logic [7:0]  mon_n = 8'd0;
  logic [7:0]  ack_n = 8'd0;
  logic [15:0] rd_dat  [0:255];
  logic [18:0] mon_adr [0:255];
  logic [1:0]  mon_sel [0:255];
  logic [15:0] mon_dat [0:255];
  logic        mon_we  [0:255];
  logic [7:0]  ack_seq [0:255];
  int x_ack_cnt = 0;
  int f_ack_cnt = 0;
  localparam logic [7:0] ACK_X = 8'h58;
  localparam logic [7:0] ACK_F = 8'h46;

  always #5 clk = ~clk;

  zet_bus_arb dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_adr(f_adr), .f_byte(f_byte), .f_dat(f_dat), .f_ack(f_ack),
    .x_req(x_req), .x_we(x_we), .x_adr(x_adr), .x_byte(x_byte), .x_wdat(x_wdat),
    .x_lock(x_lock), .x_rdat(x_rdat), .x_ack(x_ack),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Slave model: ack after ws_cfg wait states; read data comes from rd_dat in bus-cycle order.
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (ws_cnt == ws_cfg);
  assign wb_dat_i = rd_dat[mon_n];

  always @(posedge clk) begin
    ws_cnt <= (wb_stb_o && !wb_ack_i) ? ws_cnt + 4'd1 : 4'd0;
    if (wb_ack_i) mon_n <= mon_n + 8'd1;
  end

  always @(negedge clk) begin
    if (wb_ack_i) begin
      mon_adr[mon_n] <= wb_adr_o;
      mon_sel[mon_n] <= wb_sel_o;
      mon_dat[mon_n] <= wb_dat_o;
      mon_we[mon_n]  <= wb_we_o;
    end
    if (x_ack || f_ack) begin
      ack_seq[ack_n] <= x_ack ? ACK_X : ACK_F;
      ack_n <= ack_n + 8'd1;
    end
    if (x_ack) x_ack_cnt <= x_ack_cnt + 1;
    if (f_ack) f_ack_cnt <= f_ack_cnt + 1;
  end

  task automatic go_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_x, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((is_x && x_ack) || (!is_x && f_ack)) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    n_tests++; if (wb_adr_o !== 19'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", wb_adr_o); end
    n_tests++; if ({wb_sel_o, wb_dat_o} !== 18'h0) begin n_fail++; $display("FAIL reset_sel_dat: got %h want 0", {wb_sel_o, wb_dat_o}); end
    n_tests++; if ({f_ack, x_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", {f_ack, x_ack}); end
    n_tests++; if ({f_dat, x_rdat} !== 32'h0) begin n_fail++; $display("FAIL reset_rdat: got %h want 0", {f_dat, x_rdat}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_fetch;
    int lat;
    int fa;
    logic [7:0] s;
    go_edge();
    ws_cfg = 4'd0;
    s = mon_n;
    fa = f_ack_cnt;
    rd_dat[s] = 16'h1234;
    f_adr = 20'hFFFF0; f_byte = 1'b0; f_req = 1'b1;
    wait_ack(1'b0, lat);
    n_tests++; if (f_dat !== 16'h1234) begin n_fail++; $display("FAIL fetch_dat_at_ack: got %h want 1234", f_dat); end
    f_req = 1'b0;
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL fetch_latency: got %0d want 2", lat); end
    repeat (3) @(negedge clk);
    n_tests++; if (f_ack_cnt - fa !== 1) begin n_fail++; $display("FAIL fetch_ack_count: got %0d want 1", f_ack_cnt - fa); end
    n_tests++; if (mon_n - s !== 8'd1) begin n_fail++; $display("FAIL fetch_bus_cycles: got %0d want 1", mon_n - s); end
    n_tests++; if ({mon_adr[s], mon_sel[s], mon_we[s]} !== {19'h7FFF8, 2'b11, 1'b0}) begin n_fail++; $display("FAIL fetch_bus: got adr %h sel %b we %b want 7fff8 11 0", mon_adr[s], mon_sel[s], mon_we[s]); end
  endtask

  task automatic test_odd_read;
    logic [4:0] pat;
    logic [7:0] s;
    go_edge();
    ws_cfg = 4'd0;
    s = mon_n;
    rd_dat[s] = 16'hAB00;
    rd_dat[s + 8'd1] = 16'h00CD;
    x_adr = 20'h00101; x_we = 1'b0; x_byte = 1'b0; x_req = 1'b1;
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[k] = wb_stb_o;
    end
    n_tests++; if (x_ack !== 1'b1) begin n_fail++; $display("FAIL odd_read_latency: x_ack got %b want 1 after 4 cycles", x_ack); end
    n_tests++; if (x_rdat !== 16'hCDAB) begin n_fail++; $display("FAIL odd_read_dat: got %h want cdab", x_rdat); end
    x_req = 1'b0;
    n_tests++; if (pat !== 5'b01010) begin n_fail++; $display("FAIL odd_read_stb_gap: got %b want 01010", pat); end
    repeat (2) @(negedge clk);
    n_tests++; if ({mon_adr[s], mon_sel[s]} !== {19'h00080, 2'b10}) begin n_fail++; $display("FAIL odd_read_bus1: got %h %b want 00080 10", mon_adr[s], mon_sel[s]); end
    n_tests++; if ({mon_adr[s + 8'd1], mon_sel[s + 8'd1]} !== {19'h00081, 2'b01}) begin n_fail++; $display("FAIL odd_read_bus2: got %h %b want 00081 01", mon_adr[s + 8'd1], mon_sel[s + 8'd1]); end
    n_tests++; if (f_dat !== 16'h1234) begin n_fail++; $display("FAIL fetch_dat_hold: got %h want 1234", f_dat); end
  endtask

  task automatic test_odd_write;
    int lat;
    logic [7:0] s;
    go_edge();
    ws_cfg = 4'd1;
    s = mon_n;
    x_adr = 20'hFFFFF; x_we = 1'b1; x_byte = 1'b0; x_wdat = 16'h1234; x_req = 1'b1;
    wait_ack(1'b1, lat);
    x_req = 1'b0; x_we = 1'b0;
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL odd_write_latency: got %0d want 6", lat); end
    repeat (2) @(negedge clk);
    n_tests++; if ({mon_adr[s], mon_sel[s], mon_dat[s], mon_we[s]} !== {19'h7FFFF, 2'b10, 16'h3400, 1'b1}) begin n_fail++; $display("FAIL odd_write_bus1: got %h %b %h %b want 7ffff 10 3400 1", mon_adr[s], mon_sel[s], mon_dat[s], mon_we[s]); end
    n_tests++; if ({mon_adr[s + 8'd1], mon_sel[s + 8'd1], mon_dat[s + 8'd1], mon_we[s + 8'd1]} !== {19'h00000, 2'b01, 16'h0012, 1'b1}) begin n_fail++; $display("FAIL odd_write_wrap: got %h %b %h %b want 00000 01 0012 1", mon_adr[s + 8'd1], mon_sel[s + 8'd1], mon_dat[s + 8'd1], mon_we[s + 8'd1]); end
    n_tests++; if (x_rdat !== 16'hCDAB) begin n_fail++; $display("FAIL write_keeps_rdat: got %h want cdab", x_rdat); end
  endtask

  task automatic test_byte;
    int lat;
    logic [7:0] s;
    go_edge();
    ws_cfg = 4'd2;
    s = mon_n;
    rd_dat[s] = 16'h5A3C;
    x_adr = 20'h00203; x_we = 1'b0; x_byte = 1'b1; x_req = 1'b1;
    wait_ack(1'b1, lat);
    x_req = 1'b0;
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL byte_read_latency: got %0d want 4", lat); end
    n_tests++; if (x_rdat !== 16'h005A) begin n_fail++; $display("FAIL byte_read_dat: got %h want 005a", x_rdat); end
    go_edge();
    x_adr = 20'h00204; x_we = 1'b1; x_wdat = 16'hAA77; x_req = 1'b1;
    wait_ack(1'b1, lat);
    x_req = 1'b0; x_we = 1'b0; x_byte = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({mon_adr[s], mon_sel[s]} !== {19'h00101, 2'b10}) begin n_fail++; $display("FAIL byte_read_bus: got %h %b want 00101 10", mon_adr[s], mon_sel[s]); end
    n_tests++; if ({mon_adr[s + 8'd1], mon_sel[s + 8'd1], mon_dat[s + 8'd1]} !== {19'h00102, 2'b01, 16'h7777}) begin n_fail++; $display("FAIL byte_write_bus: got %h %b %h want 00102 01 7777", mon_adr[s + 8'd1], mon_sel[s + 8'd1], mon_dat[s + 8'd1]); end
  endtask

  task automatic test_back_to_back;
    int nx;
    bit fd;
    logic [7:0] a, s;
    go_edge();
    ws_cfg = 4'd0;
    a = ack_n; s = mon_n; nx = 0; fd = 1'b0;
    x_adr = 20'h00010; x_we = 1'b0; f_adr = 20'h00020;
    x_req = 1'b1; f_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (x_ack) begin
        nx++;
        if (nx == 1) x_adr = 20'h00030;
        else x_req = 1'b0;
      end
      if (f_ack) begin f_req = 1'b0; fd = 1'b1; end
      if (nx == 2 && fd) break;
    end
    x_req = 1'b0; f_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({ack_seq[a], ack_seq[a + 8'd1], ack_seq[a + 8'd2]} !== {ACK_X, ACK_F, ACK_X}) begin n_fail++; $display("FAIL b2b_order: got %s want XFX", {ack_seq[a], ack_seq[a + 8'd1], ack_seq[a + 8'd2]}); end
    n_tests++; if ({mon_adr[s], mon_adr[s + 8'd1], mon_adr[s + 8'd2]} !== {19'h00008, 19'h00010, 19'h00018}) begin n_fail++; $display("FAIL b2b_adr: got %h %h %h want 00008 00010 00018", mon_adr[s], mon_adr[s + 8'd1], mon_adr[s + 8'd2]); end
  endtask

  task automatic test_lock;
    int nx, drops;
    bit seen, early, fd;
    logic [7:0] a, s;
    go_edge();
    ws_cfg = 4'd0;
    a = ack_n; s = mon_n; nx = 0; drops = 0; seen = 1'b0; early = 1'b0; fd = 1'b0;
    x_lock = 1'b1; x_we = 1'b1; x_adr = 20'h00400; x_wdat = 16'hBEEF; x_req = 1'b1;
    f_adr = 20'h00500; f_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (seen && nx < 2 && !wb_cyc_o) drops++;
      if (wb_cyc_o) seen = 1'b1;
      if (f_ack && nx < 2) early = 1'b1;
      if (f_ack) begin f_req = 1'b0; fd = 1'b1; end
      if (x_ack) begin
        nx++;
        if (nx == 1) begin x_adr = 20'h00402; x_wdat = 16'hCAFE; end
        else begin x_req = 1'b0; x_lock = 1'b0; x_we = 1'b0; end
      end
      if (fd) break;
    end
    x_req = 1'b0; x_lock = 1'b0; x_we = 1'b0; f_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (drops !== 0) begin n_fail++; $display("FAIL lock_cyc_drop: got %0d low cycles want 0", drops); end
    n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL lock_fetch_early: got %b want 0", early); end
    n_tests++; if ({ack_seq[a], ack_seq[a + 8'd1], ack_seq[a + 8'd2]} !== {ACK_X, ACK_X, ACK_F}) begin n_fail++; $display("FAIL lock_order: got %s want XXF", {ack_seq[a], ack_seq[a + 8'd1], ack_seq[a + 8'd2]}); end
    n_tests++; if ({mon_adr[s], mon_dat[s], mon_adr[s + 8'd1], mon_dat[s + 8'd1]} !== {19'h00200, 16'hBEEF, 19'h00201, 16'hCAFE}) begin n_fail++; $display("FAIL lock_writes: got %h %h %h %h want 00200 beef 00201 cafe", mon_adr[s], mon_dat[s], mon_adr[s + 8'd1], mon_dat[s + 8'd1]); end
  endtask

  task automatic test_reset_mid;
    int xa;
    bit hit;
    logic [7:0] s;
    logic [73:0] v;
    go_edge();
    ws_cfg = 4'd3;
    s = mon_n; xa = x_ack_cnt; hit = 1'b0;
    x_adr = 20'h00301; x_we = 1'b1; x_byte = 1'b0; x_wdat = 16'h5566; x_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mon_n != s && wb_stb_o) begin hit = 1'b1; break; end
    end
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus2_reached: got %b want 1", hit); end
    #2 rst_n = 1'b0;
    x_req = 1'b0; x_we = 1'b0;
    #1;
    v = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, f_ack, x_ack, f_dat, x_rdat};
    n_tests++; if (v !== 74'h0) begin n_fail++; $display("FAIL rstmid_async_clear: got %h want 0", v); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if (x_ack_cnt - xa !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks want 0", x_ack_cnt - xa); end
    n_tests++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_idle: got %b want 0", wb_cyc_o); end
  endtask

  initial begin
    test_reset();
    test_aligned_fetch();
    test_odd_read();
    test_odd_write();
    test_byte();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
